// File: rtl/axi4_slave_read_scheduler.sv
// AXI4 slave read scheduler: in-order AR queue, beat sequencer
// and R channel driver against a synchronous-read word memory.
module axi4_slave_read_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 4,
  parameter int QDEPTH     = 4,
  parameter int MEM_BYTES  = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [ID_WIDTH-1:0]       arid,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  logic [7:0]                arlen,
  input  logic [1:0]                arburst,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [ID_WIDTH-1:0]       rid,
  output logic [1:0]                rresp,
  output logic                      rlast,
  output logic                      mem_ren,
  output logic [ADDR_WIDTH-1:0]     mem_raddr,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int BPB = DATA_WIDTH / 8;
  localparam int OW  = $clog2(BPB);
  localparam int PW  = $clog2(QDEPTH);
  localparam int CW  = PW + 1;
  localparam int EW  = ADDR_WIDTH + 9;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CAPT,
    DATA
  } state_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [1:0]            burst;
    logic                  err;
  } ent_t;

  state_t r_state;
  state_t w_next;

  ent_t          r_q [QDEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_count;

  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [7:0]            r_beats;
  logic [ID_WIDTH-1:0]   r_cur_id;
  logic [1:0]            r_cur_burst;
  logic                  r_cur_err;

  logic          w_push;
  logic          w_pop;
  logic          w_hs;
  logic [EW-1:0] w_bytes;
  logic [EW-1:0] w_end;
  logic          w_err;
  ent_t          w_ent;

  assign arready = (r_count != CW'(QDEPTH));
  assign q_count = r_count;
  assign w_push  = arvalid && arready;
  assign w_pop   = (r_state == IDLE) && (r_count != '0);
  assign w_hs    = (r_state == DATA) && rready;

  // Wide arithmetic keeps the end-of-burst address from overflowing
  assign w_bytes = (EW'(arlen) + EW'(1)) * EW'(BPB);
  assign w_end   = EW'(araddr) + w_bytes;
  assign w_err   = arburst[1] || (w_end > EW'(MEM_BYTES));

  always_comb begin
    w_ent       = '0;
    w_ent.id    = arid;
    w_ent.addr  = araddr;
    w_ent.len   = arlen;
    w_ent.burst = arburst;
    w_ent.err   = w_err;
  end

  assign rvalid    = (r_state == DATA);
  assign mem_ren   = (r_state == FETCH) && !r_cur_err;
  assign mem_raddr = (r_state == FETCH) ? (r_cur_addr >> OW) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (r_count != '0) w_next = FETCH;
      FETCH:   w_next = CAPT;
      CAPT:    w_next = DATA;
      DATA:    if (rready) w_next = rlast ? IDLE : FETCH;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QDEPTH; i++) r_q[i] <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_q[r_wp] <= w_ent;
        r_wp      <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur_addr  <= '0;
      r_beats     <= '0;
      r_cur_id    <= '0;
      r_cur_burst <= '0;
      r_cur_err   <= 1'b0;
      rdata       <= '0;
      rid         <= '0;
      rresp       <= '0;
      rlast       <= 1'b0;
    end else begin
      if (w_pop) begin
        r_cur_addr  <= r_q[r_rp].addr;
        r_beats     <= r_q[r_rp].len;
        r_cur_id    <= r_q[r_rp].id;
        r_cur_burst <= r_q[r_rp].burst;
        r_cur_err   <= r_q[r_rp].err;
      end
      if (r_state == CAPT) begin
        rdata <= r_cur_err ? '0 : mem_rdata;
        rid   <= r_cur_id;
        rresp <= r_cur_err ? 2'b10 : 2'b00;
        rlast <= (r_beats == 8'd0);
      end
      // FIXED holds the address; only INCR advances it
      if (w_hs && !rlast) begin
        r_beats <= r_beats - 8'd1;
        if (r_cur_burst == 2'b01) begin
          r_cur_addr <= r_cur_addr + ADDR_WIDTH'(BPB);
        end
      end
    end
  end

endmodule
